// File: rtl/inst_fetch_buf_pkg.sv
// Shared definitions for the instruction fetch line buffer: bus widths, line size
// default and FSM encoding (PREFETCH exists only when IFB_PREFETCH_EN is defined).
package inst_fetch_buf_pkg;

    localparam int IFB_ADDR_W         = 32;
    localparam int IFB_DATA_W         = 32;
    localparam int IFB_LINE_WORDS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
`ifdef IFB_PREFETCH_EN
        ,
        ST_PREFETCH = 2'd3
`endif
    } ifb_state_e;

endpackage

// File: rtl/inst_fetch_buf_line.sv
// ifb_line: one line buffer -- tag, per-word valid bits, word array with a single
// write port and a combinational read port.
module ifb_line
    import inst_fetch_buf_pkg::*;
#(
    parameter int LINE_WORDS = IFB_LINE_WORDS_DEF,
    parameter int TAG_W      = IFB_ADDR_W - $clog2(IFB_LINE_WORDS_DEF) - 2,
    localparam int OFF_W     = $clog2(LINE_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tag_ld,
    input  logic [TAG_W-1:0]      tag_in,
    input  logic                  clr_vld,
    input  logic                  wr_en,
    input  logic [OFF_W-1:0]      wr_idx,
    input  logic [IFB_DATA_W-1:0] wr_data,
    input  logic [OFF_W-1:0]      rd_idx,
    output logic [TAG_W-1:0]      tag_o,
    output logic [LINE_WORDS-1:0] vld_o,
    output logic [IFB_DATA_W-1:0] rd_data
);

    logic [IFB_DATA_W-1:0] words_q [LINE_WORDS];

    // Clearing (flush or new tag) wins over a same-cycle beat write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_o <= '0;
            vld_o <= '0;
        end else begin
            if (tag_ld)
                tag_o <= tag_in;
            if (clr_vld || tag_ld)
                vld_o <= '0;
            else if (wr_en)
                vld_o[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            words_q[wr_idx] <= wr_data;
    end

    assign rd_data = words_q[rd_idx];

endmodule

// File: rtl/inst_fetch_buf.sv
// inst_fetch_buf: line buffer between the core's ROM port and backing memory.
// Optional next-line prefetch into a second buffer when IFB_PREFETCH_EN is defined.
module inst_fetch_buf
    import inst_fetch_buf_pkg::*;
#(
    parameter int LINE_WORDS = IFB_LINE_WORDS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic [IFB_ADDR_W-1:0] addr_i,
    output logic [IFB_DATA_W-1:0] inst_o,
    output logic                  stall_req_o,
    input  logic                  flush_i,
    output logic                  mem_req_o,
    output logic [IFB_ADDR_W-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic [IFB_DATA_W-1:0] mem_rdata_i
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = IFB_ADDR_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);
`ifdef IFB_PREFETCH_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    logic [TAG_W-1:0] req_tag;
    logic [OFF_W-1:0] req_idx;
    logic             addr_unused;
    assign req_tag     = addr_i[IFB_ADDR_W-1 -: TAG_W];
    assign req_idx     = addr_i[OFF_W+1:2];
    assign addr_unused = ^addr_i[1:0];

    ifb_state_e            state_q, state_d;
    logic [OFF_W-1:0]      cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic [IFB_ADDR_W-1:0] maddr_q, maddr_d;
    logic                  sel_q, sel_d;    // buffer the core is reading
    logic                  fbuf_q, fbuf_d;  // buffer the beats are writing

    logic [TAG_W-1:0]      line_tag  [NBUF];
    logic [LINE_WORDS-1:0] line_vld  [NBUF];
    logic [IFB_DATA_W-1:0] line_word [NBUF];
    logic [NBUF-1:0]       line_hit, tag_ld, clr_vld, wr_en;
    logic [TAG_W-1:0]      ld_tag;
    logic                  ack_v, any_hit;

    for (genvar b = 0; b < NBUF; b++) begin : g_line
        ifb_line #(.LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)) u_line (
            .clk     (clk),
            .rst     (rst),
            .tag_ld  (tag_ld[b]),
            .tag_in  (ld_tag),
            .clr_vld (clr_vld[b]),
            .wr_en   (wr_en[b]),
            .wr_idx  (cnt_q),
            .wr_data (mem_rdata_i),
            .rd_idx  (req_idx),
            .tag_o   (line_tag[b]),
            .vld_o   (line_vld[b]),
            .rd_data (line_word[b])
        );
    end

    always_comb begin
        line_hit = '0;
        inst_o   = '0;
        for (int b = 0; b < NBUF; b++) begin
            line_hit[b] = (line_tag[b] == req_tag) && line_vld[b][req_idx];
            if (ce_i && line_hit[b])
                inst_o = line_word[b];
        end
    end

    assign any_hit     = |line_hit;
    assign stall_req_o = rst && ce_i && !any_hit;
    assign ack_v       = mem_ack_i && req_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        maddr_d = maddr_q;
        sel_d   = sel_q;
        fbuf_d  = fbuf_q;
        tag_ld  = '0;
        clr_vld = flush_i ? '1 : '0;
        wr_en   = '0;
        ld_tag  = req_tag;
        unique case (state_q)
            ST_IDLE: begin
`ifdef IFB_PREFETCH_EN
                if (ce_i && line_hit[~sel_q])
                    sel_d = ~sel_q;
`endif
                if (ce_i && !any_hit && !flush_i) begin
                    state_d        = ST_FILL;
                    tag_ld[sel_q]  = 1'b1;
                    fbuf_d         = sel_q;
                    cnt_d          = '0;
                    req_d          = 1'b1;
                    maddr_d        = {req_tag, {(OFF_W+2){1'b0}}};
                end
            end
            ST_FILL: begin
                if (flush_i) begin
                    state_d = ack_v ? ST_IDLE : ST_DRAIN;
                    req_d   = !ack_v;
                end else if (!ce_i || req_tag != line_tag[fbuf_q]) begin
                    // Core left the line: keep a just-arrived beat, otherwise drain.
                    wr_en[fbuf_q] = ack_v;
                    state_d       = ack_v ? ST_IDLE : ST_DRAIN;
                    req_d         = !ack_v;
                end else if (ack_v) begin
                    wr_en[fbuf_q] = 1'b1;
                    if (cnt_q == LAST) begin
`ifdef IFB_PREFETCH_EN
                        state_d        = ST_PREFETCH;
                        tag_ld[~fbuf_q] = 1'b1;
                        ld_tag         = line_tag[fbuf_q] + 1'b1;
                        fbuf_d         = ~fbuf_q;
                        cnt_d          = '0;
                        maddr_d        = maddr_q + 32'd4;
`else
                        state_d = ST_IDLE;
                        req_d   = 1'b0;
`endif
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        maddr_d = maddr_q + 32'd4;
                    end
                end
            end
            ST_DRAIN: begin
                if (ack_v) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
`ifdef IFB_PREFETCH_EN
            ST_PREFETCH: begin
                if (flush_i || (ce_i && !any_hit && req_tag != line_tag[fbuf_q])) begin
                    state_d = ack_v ? ST_IDLE : ST_DRAIN;
                    req_d   = !ack_v;
                end else begin
                    if (ack_v) begin
                        wr_en[fbuf_q] = 1'b1;
                        if (cnt_q == LAST) begin
                            state_d = ST_IDLE;
                            req_d   = 1'b0;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            maddr_d = maddr_q + 32'd4;
                        end
                    end
                    // Core entered the line being prefetched: it becomes the live fill.
                    if (ce_i && req_tag == line_tag[fbuf_q]) begin
                        sel_d = fbuf_q;
                        if (!(ack_v && cnt_q == LAST))
                            state_d = ST_FILL;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            maddr_q <= '0;
            sel_q   <= 1'b0;
            fbuf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            maddr_q <= maddr_d;
            sel_q   <= sel_d;
            fbuf_q  <= fbuf_d;
        end
    end

    assign mem_req_o  = req_q;
    assign mem_addr_o = maddr_q;

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf (single-buffer build): request and instruction
// scoreboards with a latency-programmable backing-memory responder.
module tb_inst_fetch_buf;

    logic        clk, rst, ce_i, flush_i;
    logic [31:0] addr_i, inst_o, mem_addr_o, mem_rdata_i;
    logic        stall_req_o, mem_req_o, mem_ack_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_req  [$];
    logic [31:0] exp_inst [$];
    bit          req_seen;
    int          wait_cnt;
    logic [31:0] cur_addr;
    int          ack_lat = 2;

    inst_fetch_buf #(.LINE_WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce_i),
        .addr_i      (addr_i),
        .inst_o      (inst_o),
        .stall_req_o (stall_req_o),
        .flush_i     (flush_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h5EED_1234 ^ {a[15:0], a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: advance to the falling edge, then act as backing memory.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        mem_ack_i = 1'b0;
        if (mem_req_o !== 1'b1 || rst !== 1'b1) begin
            req_seen = 1'b0;
        end else begin
            if (!req_seen) begin
                req_seen = 1'b1;
                wait_cnt = 0;
                cur_addr = mem_addr_o;
                e = (exp_req.size() != 0) ? exp_req.pop_front() : 32'hFFFF_FFFF;
                check("mem_addr_seq", mem_addr_o, e);
            end else begin
                wait_cnt++;
                check("mem_addr_stable", mem_addr_o, cur_addr);
            end
            if (wait_cnt == ack_lat) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem_word(mem_addr_o);
                req_seen    = 1'b0;
            end
        end
    endtask

    task automatic wait_inst(input string tag, output int cycles);
        logic [31:0] e;
        cycles = 0;
        while (stall_req_o !== 1'b0 && cycles < 60) begin
            tick();
            cycles++;
        end
        check({tag, "_stall"}, {31'd0, stall_req_o}, 32'd0);
        e = (exp_inst.size() != 0) ? exp_inst.pop_front() : 32'hFFFF_FFFF;
        check({tag, "_inst"}, inst_o, e);
    endtask

    task automatic fetch(input logic [31:0] a, input string tag, output int cycles);
        addr_i = a;
        exp_inst.push_back(mem_word(a));
        #1;
        wait_inst(tag, cycles);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (mem_req_o !== 1'b0 && k < 60) begin
            tick();
            k++;
        end
        check(tag, {31'd0, mem_req_o}, 32'd0);
    endtask

    initial begin
        int cyc;
        int k;
        rst         = 1'b0;
        ce_i        = 1'b1;
        addr_i      = 32'h0;
        flush_i     = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        req_seen    = 1'b0;
        wait_cnt    = 0;
        cur_addr    = 32'h0;

        // reset state
        repeat (3) tick();
        #1;
        check("rst_mem_req",  {31'd0, mem_req_o},   32'd0);
        check("rst_mem_addr", mem_addr_o,           32'd0);
        check("rst_stall",    {31'd0, stall_req_o}, 32'd0);
        check("rst_inst",     inst_o,               32'd0);
        tick();
        rst = 1'b1;

        // cold miss at 0x0
        for (int i = 0; i < 4; i++) exp_req.push_back(32'(i * 4));
        fetch(32'h0, "cold_w0", cyc);
        check("cold_stall_cycles", 32'(cyc), 32'd4);
        wait_idle("cold_fill_done");
        check("cold_req_all_seen", 32'(exp_req.size()), 32'd0);

        // hit inside the filled line
        fetch(32'h8, "hit_w2", cyc);
        check("hit_w2_zero_stall", 32'(cyc), 32'd0);
        check("hit_no_req", {31'd0, mem_req_o}, 32'd0);

        // chip enable low
        ce_i   = 1'b0;
        addr_i = 32'h40;
        #1;
        check("ce0_inst",  inst_o,               32'd0);
        check("ce0_stall", {31'd0, stall_req_o}, 32'd0);
        tick();
        tick();
        check("ce0_no_req", {31'd0, mem_req_o}, 32'd0);

        // stray ack while idle
        ce_i        = 1'b1;
        addr_i      = 32'hC;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hBAD0_BAD0;
        tick();
        #1;
        check("stray_ack_no_req", {31'd0, mem_req_o}, 32'd0);
        fetch(32'hC, "stray_ack_w3", cyc);
        check("stray_ack_w3_zero_stall", 32'(cyc), 32'd0);

        // flush while idle, then branch away during beat 1
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        addr_i  = 32'h4;
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h4);
        for (int i = 0; i < 4; i++) exp_req.push_back(32'h40 + 32'(i * 4));
        #1;
        check("flush_idle_miss", {31'd0, stall_req_o}, 32'd1);
        k = 0;
        while (!(mem_req_o === 1'b1 && mem_addr_o === 32'h4) && k < 60) begin
            tick();
            k++;
        end
        check("beat1_issued", mem_addr_o, 32'h4);
        addr_i = 32'h40;
        exp_inst.push_back(mem_word(32'h40));
        k = 0;
        while (mem_ack_i !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        check("drain_holds_addr", mem_addr_o,         32'h4);
        check("drain_holds_req",  {31'd0, mem_req_o}, 32'd1);
        tick();
        check("drain_then_idle", {31'd0, mem_req_o}, 32'd0);
        wait_inst("branch_tgt", cyc);
        wait_idle("branch_fill_done");
        check("branch_req_all_seen", 32'(exp_req.size()), 32'd0);

        // old line invalid; flush coincident with the beat-1 ack
        addr_i = 32'h0;
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h4);
        #1;
        check("old_line_invalid", {31'd0, stall_req_o}, 32'd1);
        k = 0;
        while (!(mem_ack_i === 1'b1 && mem_addr_o === 32'h4) && k < 60) begin
            tick();
            k++;
        end
        check("beat1_ack_seen",   mem_addr_o,           32'h4);
        check("midfill_w0_hit",   {31'd0, stall_req_o}, 32'd0);
        check("midfill_still_req", {31'd0, mem_req_o},  32'd1);
        flush_i = 1'b1;
        for (int i = 0; i < 4; i++) exp_req.push_back(32'(i * 4));
        exp_inst.push_back(mem_word(32'h0));
        tick();
        flush_i = 1'b0;
        #1;
        check("flush_over_ack", {31'd0, stall_req_o}, 32'd1);
        wait_inst("refill_w0", cyc);
        wait_idle("refill_done");
        check("refill_req_all_seen", 32'(exp_req.size()), 32'd0);
        fetch(32'h4, "refill_w1", cyc);
        check("refill_w1_zero_stall", 32'(cyc), 32'd0);

        // reset in the middle of a fill
        addr_i = 32'h80;
        exp_req.push_back(32'h80);
        #1;
        k = 0;
        while (mem_req_o !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        rst = 1'b0;
        #1;
        check("midrst_mem_req",  {31'd0, mem_req_o},   32'd0);
        check("midrst_stall",    {31'd0, stall_req_o}, 32'd0);
        check("midrst_inst",     inst_o,               32'd0);
        check("midrst_mem_addr", mem_addr_o,           32'd0);
        tick();
        tick();
        rst    = 1'b1;
        addr_i = 32'h0;
        for (int i = 0; i < 4; i++) exp_req.push_back(32'(i * 4));
        exp_inst.push_back(mem_word(32'h0));
        #1;
        check("post_rst_miss", {31'd0, stall_req_o}, 32'd1);
        wait_inst("post_rst_w0", cyc);
        wait_idle("post_rst_fill_done");
        check("post_rst_req_all_seen", 32'(exp_req.size()), 32'd0);
        check("inst_sb_empty", 32'(exp_inst.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
